// File: rtl/matriz_scan_pkg.sv
// Shared types and constants for the 8x8 LED matrix row-scan controller.
// Holds the scan FSM encoding, matrix geometry, default timing constants,
// the PWM counter width used by the optional dimming build
// (MATRIZ_SCAN_DIM_EN), and a one-hot row decode helper.
package matriz_scan_pkg;

  localparam int unsigned ROWS         = 8;
  localparam int unsigned ROW_W        = 3;
  localparam int unsigned DEF_PRESCALE = 6250;
  localparam int unsigned DEF_BLANK    = 50;
  localparam int unsigned PWM_W        = 4;

  typedef enum logic [0:0] {
    ST_BLANK   = 1'b0,
    ST_DISPLAY = 1'b1
  } scan_state_t;

  // One-hot row select for a row index.
  function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] idx);
    return ROWS'(1) << idx;
  endfunction

endpackage

// File: rtl/matriz_scan_timer.sv
// Row-period timer for the matrix scan.
// Counts 0..PRESCALE-1 on each enabled cycle and wraps to 0; holds when
// en is low. Strobes are combinational and only fire while enabled.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en            count enable
//   cnt           current counter value (registered)
//   blank_end_c   counter is at BLANK-1 and will step into the display window
//   wrap_c        counter is at PRESCALE-1 and will wrap to 0
module matriz_scan_timer #(
  parameter int unsigned PRESCALE = 6250,
  parameter int unsigned BLANK    = 50,
  parameter int unsigned CNT_W    = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             blank_end_c,
  output logic             wrap_c
);

  assign wrap_c      = en && (cnt == CNT_W'(PRESCALE - 1));
  assign blank_end_c = en && (cnt == CNT_W'(BLANK - 1));

  // Row-period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/matriz_scan_ctrl.sv
// Row-scan controller for the 8x8 LED matrix.
// Double-buffers eight row patterns (shadow written by Load_In, active swapped
// in only at frame boundaries so a frame never tears) and time-multiplexes one
// row per PRESCALE-cycle period, with BLANK all-off cycles leading each period.
// All outputs are registered and track the state/row produced on the same edge.
// Frame_Done_Out is high in the first cycle after the boundary edge (the wrap
// out of row 7), which is also the edge on which a pending frame is swapped in.
// Optional build macro MATRIZ_SCAN_DIM_EN adds MatrizScan_Brightness_In and a
// free-running 4-bit PWM that gates Col_Out during DISPLAY.
// Ports:
//   MatrizScan_CLOCK_50           clock
//   MatrizScan_RESET_InLow        asynchronous active-low reset
//   MatrizScan_Enable_In          scan enable; low freezes scan and blanks outputs
//   MatrizScan_Load_In            capture strobe for Fila1..Fila8 into shadow
//   MatrizScan_Fila1_In..Fila8_In row patterns, Fila1 is row index 0
//   MatrizScan_Brightness_In      (DIM build only) 0 = dark, 15 = full
//   MatrizScan_Load_Ack_Out       pulse the cycle after a capture
//   MatrizScan_Row_Out            one-hot row select, active high
//   MatrizScan_Col_Out            column data for the selected row
//   MatrizScan_Frame_Done_Out     pulse after the end of the row-7 period
module matriz_scan_ctrl
  import matriz_scan_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned PRESCALE  = DEF_PRESCALE,
  parameter int unsigned BLANK     = DEF_BLANK
) (
  input  logic                 MatrizScan_CLOCK_50,
  input  logic                 MatrizScan_RESET_InLow,
  input  logic                 MatrizScan_Enable_In,
  input  logic                 MatrizScan_Load_In,
  input  logic [DATAWIDTH-1:0] MatrizScan_Fila1_In,
  input  logic [DATAWIDTH-1:0] MatrizScan_Fila2_In,
  input  logic [DATAWIDTH-1:0] MatrizScan_Fila3_In,
  input  logic [DATAWIDTH-1:0] MatrizScan_Fila4_In,
  input  logic [DATAWIDTH-1:0] MatrizScan_Fila5_In,
  input  logic [DATAWIDTH-1:0] MatrizScan_Fila6_In,
  input  logic [DATAWIDTH-1:0] MatrizScan_Fila7_In,
  input  logic [DATAWIDTH-1:0] MatrizScan_Fila8_In,
`ifdef MATRIZ_SCAN_DIM_EN
  input  logic [PWM_W-1:0]     MatrizScan_Brightness_In,
`endif
  output logic                 MatrizScan_Load_Ack_Out,
  output logic [ROWS-1:0]      MatrizScan_Row_Out,
  output logic [DATAWIDTH-1:0] MatrizScan_Col_Out,
  output logic                 MatrizScan_Frame_Done_Out
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic clk;
  logic rst_n;
  logic en;
  logic load;

  assign clk   = MatrizScan_CLOCK_50;
  assign rst_n = MatrizScan_RESET_InLow;
  assign en    = MatrizScan_Enable_In;
  assign load  = MatrizScan_Load_In;

  // Row inputs gathered into an indexable array.
  logic [DATAWIDTH-1:0] fila_c [ROWS];
  assign fila_c[0] = MatrizScan_Fila1_In;
  assign fila_c[1] = MatrizScan_Fila2_In;
  assign fila_c[2] = MatrizScan_Fila3_In;
  assign fila_c[3] = MatrizScan_Fila4_In;
  assign fila_c[4] = MatrizScan_Fila5_In;
  assign fila_c[5] = MatrizScan_Fila6_In;
  assign fila_c[6] = MatrizScan_Fila7_In;
  assign fila_c[7] = MatrizScan_Fila8_In;

  logic [CNT_W-1:0]     cnt;
  logic                 blank_end_c;
  logic                 wrap_c;

  scan_state_t          state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic                 pending_q, pending_d;
  logic [DATAWIDTH-1:0] active_q [ROWS];
  logic [DATAWIDTH-1:0] shadow_q [ROWS];

  logic [ROWS-1:0]      row_out_q, row_out_d;
  logic [DATAWIDTH-1:0] col_out_q, col_out_d;
  logic                 ack_q, ack_d;
  logic                 done_q, done_d;

  logic                 boundary_c;
  logic                 swap_c;
  logic                 col_en_c;

  matriz_scan_timer #(
    .PRESCALE (PRESCALE),
    .BLANK    (BLANK),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .cnt         (cnt),
    .blank_end_c (blank_end_c),
    .wrap_c      (wrap_c)
  );

  // Frame boundary is the wrap out of the last row; swap only if a frame waits.
  assign boundary_c = wrap_c && (row_q == ROW_W'(ROWS - 1));
  assign swap_c     = boundary_c && pending_q;

`ifdef MATRIZ_SCAN_DIM_EN
  logic [PWM_W-1:0] pwm_q;

  // Free-running dimming PWM, independent of the scan enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + PWM_W'(1);
    end
  end

  // Brightness 15 is treated as always-on so full scale has no dark slot.
  assign col_en_c = (MatrizScan_Brightness_In == '1) ||
                    (pwm_q < MatrizScan_Brightness_In);
`else
  assign col_en_c = 1'b1;
`endif

  // Next-state, buffer-control and registered-output decode.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    pending_d = pending_q;
    row_out_d = '0;
    col_out_d = '0;
    ack_d     = load;
    done_d    = 1'b0;

    case (state_q)
      ST_BLANK: begin
        if (blank_end_c) begin
          state_d = ST_DISPLAY;
        end
      end
      ST_DISPLAY: begin
        if (wrap_c) begin
          state_d = ST_BLANK;
          row_d   = row_q + ROW_W'(1);
        end
      end
      default: begin
        // Recover to the phase implied by the counter.
        state_d = (cnt >= CNT_W'(BLANK)) ? ST_DISPLAY : ST_BLANK;
      end
    endcase

    if (boundary_c) begin
      done_d = 1'b1;
      if (pending_q) begin
        pending_d = 1'b0;
      end
    end

    // A capture on the boundary cycle stays pending: set wins over clear.
    if (load) begin
      pending_d = 1'b1;
    end

    if (en && (state_d == ST_DISPLAY)) begin
      row_out_d = row_onehot(row_d);
      col_out_d = col_en_c ? active_q[row_d] : '0;
    end
  end

  // State, buffers and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BLANK;
      row_q     <= '0;
      pending_q <= 1'b0;
      row_out_q <= '0;
      col_out_q <= '0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        active_q[i] <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      pending_q <= pending_d;
      row_out_q <= row_out_d;
      col_out_q <= col_out_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      // active takes the pre-capture shadow when both happen on one edge.
      for (int i = 0; i < ROWS; i++) begin
        if (load) begin
          shadow_q[i] <= fila_c[i];
        end
        if (swap_c) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign MatrizScan_Load_Ack_Out   = ack_q;
  assign MatrizScan_Row_Out        = row_out_q;
  assign MatrizScan_Col_Out        = col_out_q;
  assign MatrizScan_Frame_Done_Out = done_q;

endmodule

// File: tb/tb_matriz_scan_ctrl.sv
// Directed, table-driven bench for matriz_scan_ctrl with PRESCALE=10, BLANK=2.
// Cycle k counts clock edges since reset release; outputs are sampled 1 time
// unit after each edge.
module tb_matriz_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] fila [8];
  logic       ack;
  logic [7:0] row_o;
  logic [7:0] col_o;
  logic       done;
`ifdef MATRIZ_SCAN_DIM_EN
  logic [3:0] bright = 4'd15;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  matriz_scan_ctrl #(
    .DATAWIDTH (8),
    .PRESCALE  (10),
    .BLANK     (2)
  ) dut (
    .MatrizScan_CLOCK_50       (clk),
    .MatrizScan_RESET_InLow    (rst_n),
    .MatrizScan_Enable_In      (en),
    .MatrizScan_Load_In        (load),
    .MatrizScan_Fila1_In       (fila[0]),
    .MatrizScan_Fila2_In       (fila[1]),
    .MatrizScan_Fila3_In       (fila[2]),
    .MatrizScan_Fila4_In       (fila[3]),
    .MatrizScan_Fila5_In       (fila[4]),
    .MatrizScan_Fila6_In       (fila[5]),
    .MatrizScan_Fila7_In       (fila[6]),
    .MatrizScan_Fila8_In       (fila[7]),
`ifdef MATRIZ_SCAN_DIM_EN
    .MatrizScan_Brightness_In  (bright),
`endif
    .MatrizScan_Load_Ack_Out   (ack),
    .MatrizScan_Row_Out        (row_o),
    .MatrizScan_Col_Out        (col_o),
    .MatrizScan_Frame_Done_Out (done)
  );

  typedef struct {
    int         k;
    logic [7:0] row;
    logic [7:0] col;
    logic       ack;
    logic       done;
    logic       ld;
    logic [7:0] f1;
    logic [7:0] f3;
    logic [7:0] f8;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int k, input logic [7:0] row, input logic [7:0] col,
                              input logic ack, input logic done, input logic ld,
                              input logic [7:0] f1, input logic [7:0] f3,
                              input logic [7:0] f8);
    vec_t v;
    v.k = k; v.row = row; v.col = col; v.ack = ack; v.done = done;
    v.ld = ld; v.f1 = f1; v.f3 = f3; v.f8 = f8;
    return v;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    load = 1'b0;
    cyc++;
  endtask

  task automatic step_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic do_load(input logic [7:0] f1, input logic [7:0] f3, input logic [7:0] f8);
    for (int i = 0; i < 8; i++) fila[i] = 8'h00;
    fila[0] = f1;
    fila[2] = f3;
    fila[7] = f8;
    load = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_col;

    // k, row, col, ack, done, load?, Fila1, Fila3, Fila8
    vecs.push_back(mk(  0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(  1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(  2, 8'h01, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(  9, 8'h01, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk( 10, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk( 12, 8'h02, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk( 22, 8'h04, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk( 32, 8'h08, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk( 42, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk( 52, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk( 62, 8'h40, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk( 72, 8'h80, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk( 79, 8'h80, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk( 80, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk( 81, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk( 82, 8'h01, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(160, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    // Mid-frame load of 0x81 / 0xFF, visible only after the next boundary.
    vecs.push_back(mk(165, 8'h01, 8'h00, 0, 0, 1, 8'h81, 8'h00, 8'hFF));
    vecs.push_back(mk(166, 8'h01, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(167, 8'h01, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(232, 8'h80, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(240, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(242, 8'h01, 8'h81, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(252, 8'h02, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(312, 8'h80, 8'hFF, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(320, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    // Two loads before a boundary: last one wins, both acked.
    vecs.push_back(mk(325, 8'h01, 8'h81, 0, 0, 1, 8'h00, 8'h11, 8'h00));
    vecs.push_back(mk(326, 8'h01, 8'h81, 1, 0, 1, 8'h00, 8'h22, 8'h00));
    vecs.push_back(mk(327, 8'h01, 8'h81, 1, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(328, 8'h01, 8'h81, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(342, 8'h04, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(392, 8'h80, 8'hFF, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(400, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(402, 8'h01, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(422, 8'h04, 8'h22, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(472, 8'h80, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    // Pending 0xAA, then 0x55 captured on the boundary edge itself.
    vecs.push_back(mk(450, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'hAA, 8'h00));
    vecs.push_back(mk(451, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(479, 8'h80, 8'h00, 0, 0, 1, 8'h00, 8'h55, 8'h00));
    vecs.push_back(mk(480, 8'h00, 8'h00, 1, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(481, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(502, 8'h04, 8'hAA, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(560, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(582, 8'h04, 8'h55, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(640, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(662, 8'h04, 8'h55, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(672, 8'h08, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00));

    for (int i = 0; i < 8; i++) fila[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b1;
    cyc = 0;

    // Table entries must be in ascending k.
    vecs.sort(x) with (x.k);
    for (int i = 0; i < vecs.size(); i++) begin
      step_to(vecs[i].k);
      check("row", row_o, vecs[i].row);
      check("col", col_o, vecs[i].col);
      check("ack", {7'd0, ack}, {7'd0, vecs[i].ack});
      check("frame_done", {7'd0, done}, {7'd0, vecs[i].done});
      if (vecs[i].ld) do_load(vecs[i].f1, vecs[i].f3, vecs[i].f8);
    end

    // Enable dropped for 25 cycles in row 3 DISPLAY (counter at 5).
    step_to(675);
    check("pre_hold_row", row_o, 8'h08);
    en = 1'b0;
    for (int n = 0; n < 25; n++) begin
      step();
      check("hold_row", row_o, 8'h00);
      check("hold_col", col_o, 8'h00);
      check("hold_done", {7'd0, done}, 8'h00);
    end
    en = 1'b1;
    step();
    check("resume_row", row_o, 8'h08);
    step_to(704);
    check("resume_last_row3", row_o, 8'h08);
    step();
    check("resume_blank_row4", row_o, 8'h00);
    step_to(707);
    check("resume_row4", row_o, 8'h10);
    step_to(744);
    check("shifted_done_early", {7'd0, done}, 8'h00);
    step();
    check("shifted_done", {7'd0, done}, 8'h01);

    // Pending frame then reset mid-DISPLAY of row 2 (showing 0x55).
    step_to(765);
    do_load(8'h00, 8'h77, 8'h00);
    step();
    check("pre_reset_ack", {7'd0, ack}, 8'h01);
    step_to(770);
    check("pre_reset_row", row_o, 8'h04);
    check("pre_reset_col", col_o, 8'h55);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_row", row_o, 8'h00);
    check("async_reset_col", col_o, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
`ifdef MATRIZ_SCAN_DIM_EN
    bright = 4'd4;
`endif
    step_to(2);
    check("post_reset_row0", row_o, 8'h01);
    check("post_reset_col0", col_o, 8'h00);
    step_to(22);
    check("post_reset_row2", row_o, 8'h04);
    check("post_reset_col2", col_o, 8'h00);
    step_to(80);
    check("post_reset_done", {7'd0, done}, 8'h01);
    step_to(102);
    check("discarded_pending", col_o, 8'h00);

    // Full row 0 for the brightness checks.
    step_to(105);
    do_load(8'hFF, 8'h00, 8'h00);
    step();
    check("bright_load_ack", {7'd0, ack}, 8'h01);
    step_to(160);
    check("bright_swap_done", {7'd0, done}, 8'h01);
    for (int k = 162; k <= 169; k++) begin
      step_to(k);
      check("bright_row", row_o, 8'h01);
`ifdef MATRIZ_SCAN_DIM_EN
      // PWM sampled at edge k holds (k-1) mod 16; brightness 4 lights pwm 0..3.
      exp_col = (((k - 1) % 16) < 4) ? 8'hFF : 8'h00;
`else
      exp_col = 8'hFF;
`endif
      check("bright_col", col_o, exp_col);
    end
`ifdef MATRIZ_SCAN_DIM_EN
    bright = 4'd15;
`endif
    for (int k = 242; k <= 249; k++) begin
      step_to(k);
      check("full_bright_col", col_o, 8'hFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
